stream_filter_cfg: RTL



---
 rtl/stream_filter_pkg.sv | 36 +++
 rtl/sat_counter.sv | 24 ++
 rtl/stream_filter_cfg.sv | 117 +++++++++++
 3 files changed

// File: rtl/stream_filter_pkg.sv
// Shared definitions for the stream_filter configuration path: register map,
// parameter-set geometry and the sequencer state encoding.
package stream_filter_pkg;

  // Filter configuration register addresses
  localparam int unsigned CFG_WIDTH   = 1;  // line width
  localparam int unsigned CFG_KERNEL  = 2;  // kernel taps, row-major
  localparam int unsigned CFG_RESCALE = 3;  // {shift[15:8], head[7:0]}

  // Parameter-set geometry: one width word, nine taps, one rescale word
  localparam int unsigned NUM_WORDS = 11;
  localparam int unsigned KER_TAPS  = 9;

  localparam int WCNT_W = 4;
  typedef logic [WCNT_W-1:0] wcnt_t;
  localparam wcnt_t LAST_WORD = wcnt_t'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Register address targeted by the idx-th word of a parameter set
  function automatic logic [7:0] word_addr(input wcnt_t idx);
    logic [7:0] addr;
    if (idx == '0)
      addr = 8'(CFG_WIDTH);
    else if (idx <= wcnt_t'(KER_TAPS))
      addr = 8'(CFG_KERNEL);
    else
      addr = 8'(CFG_RESCALE);
    return addr;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count events, clear has priority, hold at saturation
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/stream_filter_cfg.sv
// Configuration sequencer and pixel gate in front of stream_filter. Replays an
// 11-word host parameter set as filter register writes, forwards pixels only
// while a full configuration is loaded, and drains the filter pipeline before
// accepting a new parameter set.
module stream_filter_cfg
  import stream_filter_pkg::*;
#(
  parameter int CFG_DWIDTH   = 32,
  parameter int CFG_AWIDTH   = 5,
  parameter int IMG_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CFG_DWIDTH-1:0] host_data,
  input  logic                  host_val,
  output logic                  host_rdy,
  input  logic [IMG_WIDTH-1:0]  pix,
  input  logic                  pix_val,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic                  cfg_valid,
  output logic [IMG_WIDTH-1:0]  image,
  output logic                  image_val,
  output logic                  cfg_done,
  output logic [CNT_WIDTH-1:0]  pix_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t            state, state_nxt;
  wcnt_t             wcnt;
  logic [DRN_W-1:0]  drain_cnt;

  // host_rdy is a register, so the handshake never loops back through host_val
  logic hs, last_word, fwd, drop;
  assign hs        = host_val & host_rdy;
  assign last_word = hs && (wcnt == LAST_WORD);
  assign fwd       = pix_val && (state == ST_STREAM);
  assign drop      = pix_val && (state != ST_STREAM);

  // Next-state decode
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      ST_LOAD:   if (last_word)          state_nxt = ST_STREAM;
      ST_STREAM: if (host_val)           state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt == '0)    state_nxt = ST_LOAD;
      default:                           state_nxt = ST_LOAD;
    endcase
  end

  // State, word counter, drain timer and the state-derived status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      wcnt      <= '0;
      drain_cnt <= '0;
      host_rdy  <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      host_rdy <= (state_nxt == ST_LOAD);
      cfg_done <= (state_nxt == ST_STREAM);
      if (hs)
        wcnt <= last_word ? '0 : wcnt + 1'b1;
      if ((state == ST_STREAM) && host_val)
        drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
      else if ((state == ST_DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Config write port: one strobe per accepted word, zeroed when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
    end else begin
      cfg_valid <= hs;
      cfg_addr  <= hs ? CFG_AWIDTH'(word_addr(wcnt)) : '0;
      cfg_data  <= hs ? host_data : '0;
    end
  end

  // Pixel gate: pass-through with one register stage, zero when blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_val <= 1'b0;
      image     <= '0;
    end else begin
      image_val <= fwd;
      image     <= fwd ? pix : '0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pix_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (last_word),
    .inc   (fwd),
    .count (pix_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (drop),
    .count (drop_cnt)
  );

endmodule
